// File: rtl/counter_if.sv
// Count interface: carries the count enable from the controlling block to the
// counter and the registered count value back.
interface counter_if #(
    parameter int SIZE = 4
);
    logic            enable;
    logic [SIZE-1:0] counter_output;

    // Controlling side: drives enable, observes the count.
    modport master (
        output enable,
        input  counter_output
    );

    // Counter side: samples enable, drives the count.
    modport slave (
        input  enable,
        output counter_output
    );
endinterface

// File: rtl/counter.sv
// Wrap-around up-counter: counts 0..MAX_VALUE on enabled clock edges, then
// returns to 0. Asynchronous active-low reset clears the count at once.
module counter #(
    parameter int SIZE      = 4,
    parameter int MAX_VALUE = (2 ** SIZE) - 1
) (
    input  logic      clk,
    input  logic      reset,
    counter_if.slave  bus
);

    // Reject widths of zero and terminal values that cannot be represented.
    if (SIZE < 1) begin : g_bad_size
        $error("counter: SIZE must be at least 1");
    end
    if (MAX_VALUE < 0) begin : g_bad_max_neg
        $error("counter: MAX_VALUE must not be negative");
    end
    if (longint'(MAX_VALUE) >= (longint'(1) << SIZE)) begin : g_bad_max_range
        $error("counter: MAX_VALUE must be below 2**SIZE");
    end

    // Terminal value truncated to the counter width for an exact compare.
    localparam logic [SIZE-1:0] MAX_CNT = SIZE'(MAX_VALUE);

    logic [SIZE-1:0] count;
    logic            at_max;
    logic            over_max;

    // Terminal detect; an out-of-range state is treated like the terminal
    // value so the next enabled edge recovers to 0.
    always_comb begin
        at_max   = (count == MAX_CNT);
        over_max = (count > MAX_CNT);
    end

    // Count register: reset clears, enable advances or wraps, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (bus.enable) begin
            if (at_max || over_max) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign bus.counter_output = count;

endmodule

// File: tb/tb_counter.sv
// Bench for counter: vector table for the directed scenarios, hand sequences
// for async reset and full-range wrap, then random stimulus against a model.
module tb_counter;

    logic clk;
    logic reset;
    logic enable;

    int checks;
    int errors;

    counter_if #(.SIZE(4)) bus10 ();
    counter_if #(.SIZE(4)) bus15 ();
    counter_if #(.SIZE(4)) bus0  ();

    assign bus10.enable = enable;
    assign bus15.enable = enable;
    assign bus0.enable  = enable;

    counter #(.SIZE(4), .MAX_VALUE(10)) dut10 (.clk(clk), .reset(reset), .bus(bus10));
    counter #(.SIZE(4), .MAX_VALUE(15)) dut15 (.clk(clk), .reset(reset), .bus(bus15));
    counter #(.SIZE(4), .MAX_VALUE(0))  dut0  (.clk(clk), .reset(reset), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] exp;
        logic       async_chk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input int x, input logic a);
        vec_t v;
        v.rst_n     = r;
        v.en        = e;
        v.exp       = 4'(x);
        v.async_chk = a;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, then let the rising edge happen and settle.
    task automatic step(input logic r, input logic e);
        @(negedge clk);
        reset  = r;
        enable = e;
        @(posedge clk);
        #1;
    endtask

    int m10, m15, m0;
    logic r_rand, e_rand;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        enable = 1'b0;

        // Directed scenarios for MAX_VALUE=10.
        add(0, 0, 0, 0);                                 // reset state
        add(0, 1, 0, 0);                                 // reset beats enable
        for (int i = 1; i <= 3; i++) add(1, 1, i, 0);    // 1,2,3
        add(0, 1, 0, 1);                                 // async clear from 3
        add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0);     // release, disabled
        for (int i = 1; i <= 10; i++) add(1, 1, i, 0);   // up to terminal
        add(1, 1, 0, 0);                                 // wrap
        for (int i = 1; i <= 5; i++) add(1, 1, i, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 5, 0);     // hold
        add(1, 1, 6, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset  = vecs[i].rst_n;
            enable = vecs[i].en;
            if (vecs[i].async_chk) begin
                #1;
                check($sformatf("async_clear[%0d]", i), int'(bus10.counter_output), 0);
            end
            @(posedge clk);
            #1;
            check($sformatf("vec10[%0d]", i), int'(bus10.counter_output), int'(vecs[i].exp));
            check($sformatf("vec0[%0d]", i), int'(bus0.counter_output), 0);
        end

        // Async clear mid-cycle from a non-zero count, before any rising edge.
        step(1, 1);
        step(1, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_mid_cycle", int'(bus10.counter_output), 0);

        // Full-range wrap for MAX_VALUE=15: 14,15,0,1.
        step(0, 0);
        for (int i = 0; i < 14; i++) step(1, 1);
        check("full_range_14", int'(bus15.counter_output), 14);
        step(1, 1);
        check("full_range_15", int'(bus15.counter_output), 15);
        step(1, 1);
        check("full_range_0", int'(bus15.counter_output), 0);
        check("max10_after_16", int'(bus10.counter_output), 5);
        step(1, 1);
        check("full_range_1", int'(bus15.counter_output), 1);
        check("max0_const", int'(bus0.counter_output), 0);

        // Random stimulus against a modulo-arithmetic model.
        step(0, 0);
        m10 = 0;
        m15 = 0;
        m0  = 0;
        for (int i = 0; i < 400; i++) begin
            r_rand = ($urandom_range(0, 15) != 0);
            e_rand = ($urandom_range(0, 3) != 0);
            step(r_rand, e_rand);
            if (!r_rand) begin
                m10 = 0;
                m15 = 0;
                m0  = 0;
            end else if (e_rand) begin
                m10 = (m10 + 1) % 11;
                m15 = (m15 + 1) % 16;
                m0  = (m0 + 1) % 1;
            end
            check($sformatf("rand10[%0d]", i), int'(bus10.counter_output), m10);
            check($sformatf("rand15[%0d]", i), int'(bus15.counter_output), m15);
            check($sformatf("rand0[%0d]", i),  int'(bus0.counter_output),  m0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
